icache_ctrl: RTL and testbench



---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_array.sv | 60 ++++++
 rtl/icache_ctrl.sv | 170 +++++++++++++++++
 tb/tb_icache_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 64;

  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_NUM_LINES);
  localparam int TAG_W = DEF_ADDR_W - 2 - OFF_W - IDX_W;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational read, one write port, synchronous invalidate-all.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int OFF_BITS   = OFF_W,
  parameter int IDX_BITS   = IDX_W,
  parameter int TAG_BITS   = TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [OFF_BITS-1:0] rd_off,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [31:0]         rd_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [OFF_BITS-1:0] wr_off,
  input  logic [31:0]         wr_data,
  input  logic                tag_we,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic                inv_all
);

  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_BITS-1:0]  tag_r  [NUM_LINES];
  logic [31:0]          data_r [NUM_LINES*LINE_WORDS];

  // Valid bits: reset and invalidate-all take priority over a line install.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {NUM_LINES{1'b0}};
    end else if (inv_all) begin
      valid_r <= {NUM_LINES{1'b0}};
    end else if (tag_we) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag storage, written with the last beat of a refill.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_r[wr_idx] <= wr_tag;
    end
  end

  // Data storage, one word per refill beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_r[{wr_idx, wr_off}] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_data  = data_r[{rd_idx, rd_off}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache lookup plus line refill FSM (req/ack/beat handshake).
// Optional hit/miss performance counters enabled by defining ICACHE_PERF_CNT_EN.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [ADDR_W-1:0] i_PC,
  input  logic              i_Fetch_En,
  input  logic              i_Invalidate,
  output logic [31:0]       o_Instr,
  output logic              o_ICache_Miss,
  output logic              o_Mem_Req,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  input  logic              i_Mem_Ack,
  input  logic              i_Mem_Valid,
  input  logic [31:0]       i_Mem_Data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       o_Hit_Cnt,
  output logic [31:0]       o_Miss_Cnt
`endif
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_W - 2 - OW - IW;
  localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);
  localparam logic [OW-1:0] BEAT_ONE  = OW'(1);

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] miss_addr_r;
  logic [OW-1:0]     beat_cnt_r;
  logic              inv_pending_r;

  logic [OW-1:0] pc_off_s;
  logic [IW-1:0] pc_idx_s, miss_idx_s;
  logic [TW-1:0] pc_tag_s, miss_tag_s, rd_tag_s;
  logic [31:0]   rd_data_s;
  logic          rd_valid_s, hit_s, fill_beat_s, fill_last_s, inv_all_s;
  logic          miss_s, start_miss_s;
  logic          pc_unused_s;

  assign pc_off_s    = i_PC[2 +: OW];
  assign pc_idx_s    = i_PC[2+OW +: IW];
  assign pc_tag_s    = i_PC[ADDR_W-1 -: TW];
  assign pc_unused_s = ^i_PC[1:0];
  assign miss_idx_s  = miss_addr_r[2+OW +: IW];
  assign miss_tag_s  = miss_addr_r[ADDR_W-1 -: TW];

  assign hit_s       = i_Fetch_En & rd_valid_s & (rd_tag_s == pc_tag_s) & (state_r == IDLE);
  assign fill_beat_s = (state_r == FILL) & i_Mem_Valid;
  assign fill_last_s = fill_beat_s & (beat_cnt_r == LAST_BEAT);
  // A pending invalidate is applied on the DONE->IDLE edge, after the new line is installed.
  assign inv_all_s   = ((state_r == IDLE) & i_Invalidate) |
                       ((state_r == DONE) & (inv_pending_r | i_Invalidate));

  icache_array #(
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .OFF_BITS   (OW),
    .IDX_BITS   (IW),
    .TAG_BITS   (TW)
  ) u_array (
    .clk      (i_Clk),
    .rst      (i_Reset),
    .rd_idx   (pc_idx_s),
    .rd_off   (pc_off_s),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (fill_beat_s),
    .wr_idx   (miss_idx_s),
    .wr_off   (beat_cnt_r),
    .wr_data  (i_Mem_Data),
    .tag_we   (fill_last_s),
    .wr_tag   (miss_tag_s),
    .inv_all  (inv_all_s)
  );

  // Next-state and miss indication for the refill FSM.
  always_comb begin
    state_nxt_s  = state_r;
    miss_s       = 1'b1;
    start_miss_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_Fetch_En & ~hit_s) begin
          state_nxt_s  = REQ;
          start_miss_s = 1'b1;
        end else begin
          miss_s = 1'b0;
        end
      end
      REQ: begin
        if (i_Mem_Ack) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = REQ;
        end
      end
      FILL: begin
        if (fill_last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = FILL;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, latched miss line, beat counter and deferred invalidate.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r       <= IDLE;
      miss_addr_r   <= {ADDR_W{1'b0}};
      beat_cnt_r    <= {OW{1'b0}};
      inv_pending_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (start_miss_s) begin
        miss_addr_r <= {i_PC[ADDR_W-1:2+OW], {(2+OW){1'b0}}};
      end
      if (state_r == REQ) begin
        beat_cnt_r <= {OW{1'b0}};
      end else if (fill_beat_s) begin
        beat_cnt_r <= beat_cnt_r + BEAT_ONE;
      end
      if ((state_r != IDLE) && (state_nxt_s == IDLE)) begin
        inv_pending_r <= 1'b0;
      end else if ((state_r != IDLE) && i_Invalidate) begin
        inv_pending_r <= 1'b1;
      end
    end
  end

  assign o_ICache_Miss = miss_s;
  assign o_Instr       = hit_s ? rd_data_s : NOP_INSTR;
  assign o_Mem_Req     = (state_r == REQ);
  assign o_Mem_Addr    = (state_r == REQ) ? miss_addr_r : {ADDR_W{1'b0}};

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Free-running hit/miss event counters, wrapping modulo 2^32.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if (hit_s) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (start_miss_s) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign o_Hit_Cnt  = hit_cnt_r;
  assign o_Miss_Cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus randomized traffic vs. a cache model.
module tb_icache_ctrl;

  localparam int LW = 4;
  localparam int NL = 64;

  logic        clk;
  logic        i_Reset, i_Fetch_En, i_Invalidate, i_Mem_Ack, i_Mem_Valid;
  logic [31:0] i_PC, i_Mem_Data;
  logic [31:0] o_Instr, o_Mem_Addr;
  logic        o_ICache_Miss, o_Mem_Req;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] o_Hit_Cnt, o_Miss_Cnt;
`endif

  icache_ctrl dut (
    .i_Clk         (clk),
    .i_Reset       (i_Reset),
    .i_PC          (i_PC),
    .i_Fetch_En    (i_Fetch_En),
    .i_Invalidate  (i_Invalidate),
    .o_Instr       (o_Instr),
    .o_ICache_Miss (o_ICache_Miss),
    .o_Mem_Req     (o_Mem_Req),
    .o_Mem_Addr    (o_Mem_Addr),
    .i_Mem_Ack     (i_Mem_Ack),
    .i_Mem_Valid   (i_Mem_Valid),
    .i_Mem_Data    (i_Mem_Data)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .o_Hit_Cnt     (o_Hit_Cnt),
    .o_Miss_Cnt    (o_Miss_Cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model: cache contents plus the progress of the one outstanding refill.
  bit [NL-1:0]  m_valid;
  logic [21:0]  m_tag  [NL];
  logic [31:0]  m_data [NL][LW];
  bit           m_busy, m_acked, m_done, m_inv;
  int           m_beats;
  logic [31:0]  m_base;
  int unsigned  m_hits, m_misses;

  function automatic int f_idx(logic [31:0] a);  return int'(a[9:4]);  endfunction
  function automatic int f_off(logic [31:0] a);  return int'(a[3:2]);  endfunction
  function automatic logic [21:0] f_tag(logic [31:0] a); return a[31:10]; endfunction

  function automatic bit model_hit();
    return !m_busy && i_Fetch_En && m_valid[f_idx(i_PC)] && (m_tag[f_idx(i_PC)] == f_tag(i_PC));
  endfunction

  // Model update at every rising edge using the inputs the DUT sampled.
  initial forever begin
    @(posedge clk);
    if (i_Reset) begin
      m_valid = '0; m_busy = 0; m_acked = 0; m_done = 0; m_inv = 0; m_beats = 0;
      m_hits = 0; m_misses = 0;
    end else if (!m_busy) begin
      bit h;
      h = model_hit();
      if (h) m_hits++;
      if (i_Invalidate) m_valid = '0;
      if (i_Fetch_En && !h) begin
        m_busy = 1; m_acked = 0; m_done = 0;
        m_base = {i_PC[31:4], 4'h0};
        m_misses++;
      end
    end else begin
      if (i_Invalidate) m_inv = 1;
      if (m_done) begin
        if (m_inv) m_valid = '0;
        m_busy = 0; m_done = 0; m_inv = 0;
      end else if (!m_acked) begin
        if (i_Mem_Ack) begin m_acked = 1; m_beats = 0; end
      end else if (i_Mem_Valid) begin
        m_data[f_idx(m_base)][m_beats] = i_Mem_Data;
        m_beats++;
        if (m_beats == LW) begin
          m_tag[f_idx(m_base)] = f_tag(m_base);
          m_valid[f_idx(m_base)] = 1'b1;
          m_done = 1; m_acked = 0;
        end
      end
    end
  end

  // Compare process: DUT outputs against the model, mid-cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit h, exp_req;
      h = model_hit();
      exp_req = m_busy && !m_acked && !m_done;
      check("miss", o_ICache_Miss, m_busy || (i_Fetch_En && !h));
      check("mem_req", o_Mem_Req, exp_req);
      if (exp_req) check("mem_addr", o_Mem_Addr, m_base);
      check("instr", o_Instr, h ? m_data[f_idx(i_PC)][f_off(i_PC)] : 32'h0);
`ifdef ICACHE_PERF_CNT_EN
      check("hit_cnt", o_Hit_Cnt, m_hits);
      check("miss_cnt", o_Miss_Cnt, m_misses);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // From a REQ cycle: ack, then four back-to-back beats, then the DONE cycle.
  task automatic fill_from_req(input logic [31:0] base, input logic [31:0] d0, input int inv_at);
    i_Mem_Ack = 1'b1;
    neg(); check("req_hold", o_Mem_Req, 1'b1); check("req_addr", o_Mem_Addr, base);
    cyc();
    i_Mem_Ack = 1'b0;
    for (int k = 0; k < LW; k++) begin
      i_Mem_Valid = 1'b1; i_Mem_Data = d0 + k; i_Invalidate = (k == inv_at);
      cyc();
    end
    i_Mem_Valid = 1'b0; i_Invalidate = 1'b0;
    neg(); check("fill_done_miss", o_ICache_Miss, 1'b1);
    cyc();
  endtask

  task automatic refill(input logic [31:0] pc, input logic [31:0] d0, input int inv_at);
    i_PC = pc; i_Fetch_En = 1'b1; i_Mem_Ack = 1'b0; i_Mem_Valid = 1'b0;
    neg(); check("refill_miss", o_ICache_Miss, 1'b1);
    cyc();
    fill_from_req({pc[31:4], 4'h0}, d0, inv_at);
  endtask

  initial begin
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int k;
    i_Reset = 1'b1; i_PC = 32'h0; i_Fetch_En = 1'b0; i_Invalidate = 1'b0;
    i_Mem_Ack = 1'b0; i_Mem_Valid = 1'b0; i_Mem_Data = 32'h0;
    cyc(); cyc();
    i_Reset = 1'b0;
    chk_en = 1'b1;

    // Cold miss with gapped beats.
    i_PC = 32'h100; i_Fetch_En = 1'b1;
    neg(); check("cold_miss", o_ICache_Miss, 1'b1); check("cold_noreq_idle", o_Mem_Req, 1'b0);
    cyc();
    neg(); check("cold_req", o_Mem_Req, 1'b1); check("cold_addr", o_Mem_Addr, 32'h100);
    cyc();
    i_Mem_Ack = 1'b1; cyc(); i_Mem_Ack = 1'b0;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      i_Mem_Valid = pat[i][0];
      i_Mem_Data  = pat[i] != 0 ? 32'hA0 + k : 32'hDEADBEEF;
      if (pat[i] != 0) k++;
      neg(); check("gap_stall", o_ICache_Miss, 1'b1);
      cyc();
    end
    i_Mem_Valid = 1'b0;
    neg(); check("done_miss", o_ICache_Miss, 1'b1); check("done_instr", o_Instr, 32'h0);
    cyc();
    for (int w = 0; w < LW; w++) begin
      i_PC = 32'h100 + 4 * w;
      neg(); check("cold_hit_miss", o_ICache_Miss, 1'b0);
      check("cold_hit_instr", o_Instr, 32'hA0 + w); check("cold_hit_noreq", o_Mem_Req, 1'b0);
      cyc();
    end
    i_Fetch_En = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    neg(); check("perf_hits", o_Hit_Cnt, 32'd4); check("perf_misses", o_Miss_Cnt, 32'd1);
`endif
    cyc();

    // Conflict miss on the same index, then the evicted line misses again.
    refill(32'h500, 32'hB0, -1);
    neg(); check("conf_hit", o_ICache_Miss, 1'b0); check("conf_instr", o_Instr, 32'hB0);
    cyc();
    refill(32'h100, 32'hC0, -1);
    neg(); check("reload_instr", o_Instr, 32'hC0);
    cyc();

    // Invalidate during FILL at beat 2: the filled line is dropped on return to IDLE.
    refill(32'h208, 32'hD0, 2);
    neg(); check("inv_miss", o_ICache_Miss, 1'b1);
    cyc();
    fill_from_req(32'h200, 32'hE0, -1);
    neg(); check("inv_refill_instr", o_Instr, 32'hE2);
    cyc();

    // Reset in the middle of FILL.
    i_PC = 32'h600; cyc();
    i_Mem_Ack = 1'b1; cyc(); i_Mem_Ack = 1'b0;
    i_Mem_Valid = 1'b1; i_Mem_Data = 32'h11; cyc();
    i_Reset = 1'b1; cyc();
    i_Reset = 1'b0; i_Fetch_En = 1'b0; i_PC = 32'h7F0; i_Mem_Data = 32'h22;
    neg(); check("rst_req_low", o_Mem_Req, 1'b0); check("fe0_no_miss", o_ICache_Miss, 1'b0);
    cyc();
    i_Mem_Valid = 1'b0;
    neg(); check("fe0_no_req", o_Mem_Req, 1'b0);
    i_PC = 32'h200; i_Fetch_En = 1'b1;
    #1; check("rst_lost_line", o_ICache_Miss, 1'b1);
    cyc();

    // Randomized traffic over a small address pool to mix hits, conflicts and refills.
    for (int c = 0; c < 4000; c++) begin
      i_Reset      = ($urandom_range(0, 199) == 0);
      i_PC         = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      i_Fetch_En   = ($urandom_range(0, 9) != 0);
      i_Invalidate = ($urandom_range(0, 49) == 0);
      i_Mem_Ack    = ($urandom_range(0, 2) == 0);
      i_Mem_Valid  = $urandom_range(0, 1) != 0;
      i_Mem_Data   = $urandom;
      cyc();
    end
    i_Reset = 1'b0; i_Fetch_En = 1'b0; i_Invalidate = 1'b0; i_Mem_Ack = 1'b0; i_Mem_Valid = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
